// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester, transmitter and status signals of the UART TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       active_id;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 uart_ready;
    logic                 tx_timeout;
    logic                 arb_busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, uart_ready,
        output req_ack, grant, active_id, tx_data, tx_start, tx_timeout, arb_busy
    );

    // Requester / transmitter side
    modport master (
        output req_valid, req_data, req_last, uart_ready,
        input  req_ack, grant, active_id, tx_data, tx_start, tx_timeout, arb_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin packet arbiter feeding one UART transmitter byte by
//            byte, with per-grant byte cap and busy-handshake timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDW       = 2,
    parameter int MAX_BYTES = 16,
    parameter int BUSY_TO   = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int c_TMR_W = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t               state_q,      state_d;
    logic [IDW-1:0]       rr_ptr_q,     rr_ptr_d;
    logic [7:0]           byte_cnt_q,   byte_cnt_d;
    logic                 last_f_q,     last_f_d;
    logic [c_TMR_W-1:0]   timer_q,      timer_d;
    logic [NUM_REQ-1:0]   grant_q,      grant_d;
    logic [NUM_REQ-1:0]   req_ack_q,    req_ack_d;
    logic [IDW-1:0]       active_id_q,  active_id_d;
    logic [7:0]           tx_data_q,    tx_data_d;
    logic                 tx_start_q,   tx_start_d;
    logic                 tx_timeout_q, tx_timeout_d;
    logic                 arb_busy_q,   arb_busy_d;

    logic                 w_win_found;
    logic [IDW-1:0]       w_win_id;
    logic [IDW:0]         w_sum;
    logic                 w_own_valid;
    logic [7:0]           w_own_data;
    logic                 w_own_last;
    logic [IDW-1:0]       w_next_ptr;

    // Rotating priority search starting at rr_ptr, wrapping at NUM_REQ
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_sum       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end
            if (!w_win_found && bus.req_valid[w_sum[IDW-1:0]]) begin
                w_win_found = 1'b1;
                w_win_id    = w_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_own_valid = 1'b0;
        w_own_data  = 8'h00;
        w_own_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (active_id_q == IDW'(i)) begin
                w_own_valid = bus.req_valid[i];
                w_own_data  = bus.req_data[8*i +: 8];
                w_own_last  = bus.req_last[i];
            end
        end
    end

    assign w_next_ptr = (active_id_q == IDW'(NUM_REQ - 1)) ? '0 : active_id_q + IDW'(1);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        last_f_d     = last_f_q;
        timer_d      = timer_q;
        grant_d      = grant_q;
        active_id_d  = active_id_q;
        tx_data_d    = tx_data_q;
        req_ack_d    = '0;
        tx_start_d   = 1'b0;
        tx_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_win_found) begin
                    grant_d     = NUM_REQ'(1) << w_win_id;
                    active_id_d = w_win_id;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (!w_own_valid) begin
                    grant_d    = '0;
                    rr_ptr_d   = w_next_ptr;
                    byte_cnt_d = 8'd0;
                    last_f_d   = 1'b0;
                    state_d    = S_IDLE;
                end else if (bus.uart_ready) begin
                    tx_data_d  = w_own_data;
                    tx_start_d = 1'b1;
                    req_ack_d  = grant_q;
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    // The cap turns the MAX_BYTES-th byte into a forced last
                    last_f_d   = w_own_last | (byte_cnt_q == 8'(MAX_BYTES - 1));
                    timer_d    = '0;
                    state_d    = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!bus.uart_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == c_TMR_W'(BUSY_TO - 1)) begin
                    tx_timeout_d = 1'b1;
                    state_d      = S_WAIT_DONE;
                end else begin
                    timer_d = timer_q + c_TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (bus.uart_ready) begin
                    if (last_f_q) begin
                        grant_d    = '0;
                        rr_ptr_d   = w_next_ptr;
                        byte_cnt_d = 8'd0;
                        last_f_d   = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        arb_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            byte_cnt_q   <= 8'd0;
            last_f_q     <= 1'b0;
            timer_q      <= '0;
            grant_q      <= '0;
            req_ack_q    <= '0;
            active_id_q  <= '0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            tx_timeout_q <= 1'b0;
            arb_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            last_f_q     <= last_f_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            req_ack_q    <= req_ack_d;
            active_id_q  <= active_id_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            tx_timeout_q <= tx_timeout_d;
            arb_busy_q   <= arb_busy_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.req_ack    = req_ack_q;
    assign bus.active_id  = active_id_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_timeout = tx_timeout_q;
    assign bus.arb_busy   = arb_busy_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter (the top_tx serial datapath) among NUM_REQ byte-stream requesters. It grants one requester for a whole packet and sequences the transmitter byte by byte. For each byte it issues a one-cycle start pulse and tracks the transmitter's ready/busy handshake. It also enforces a per-grant byte cap so that no requester can starve the others.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDW, 2, width of active_id; must equal clog2(NUM_REQ)
MAX_BYTES, 16, maximum bytes sent per grant before forced release (1..255)
BUSY_TO, 8, cycles to wait for uart_ready to fall after tx_start before declaring timeout (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester "byte available" flag
req_data  in  8*NUM_REQ  packed bytes; requester i occupies bits [8i+7:8i]
req_last  in  NUM_REQ  current byte of requester i is the last of its packet
req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
grant  out  NUM_REQ  one-hot current owner; all zero when idle
active_id  out  IDW  binary index of current owner; held at last owner when idle
tx_data  out  8  byte to transmitter; held stable until the next load
tx_start  out  1  one-cycle pulse that launches a transmit
uart_ready  in  1  transmitter idle (high) / busy (low)
tx_timeout  out  1  one-cycle pulse when uart_ready does not fall within BUSY_TO cycles
arb_busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (asynchronous, immediate): grant=0, req_ack=0, tx_start=0, tx_data=8'h00, active_id=0, tx_timeout=0, arb_busy=0, rr_ptr=0, byte_cnt=0, state=IDLE.
- All outputs are registered.
- IDLE:
  - If any req_valid is high, select the first set bit searching from rr_ptr upward with wrap-around.
  - Next cycle: grant=onehot(winner), active_id=winner, state=SEND.
- SEND (owner g):
  - If req_valid[g]=0: release.
  - Else, if uart_ready=1, all of the following occur on the next edge:
    - tx_data<=req_data[g]
    - tx_start<=1 and req_ack[g]<=1, each for exactly one cycle
    - byte_cnt<=byte_cnt+1
    - last_f<=req_last[g] OR (byte_cnt==MAX_BYTES-1)
    - state=WAIT_BUSY
  - Else (uart_ready=0): remain in SEND.
- Requester rule: req_data and req_last must advance on the cycle after req_ack.
- WAIT_BUSY:
  - A timer counts from the tx_start cycle.
  - When uart_ready=0, go to WAIT_DONE.
  - If the timer reaches BUSY_TO with uart_ready still 1, pulse tx_timeout and go to WAIT_DONE.
- WAIT_DONE:
  - Wait for uart_ready=1.
  - Then: if last_f, release; else go to SEND.
- Release (single cycle):
  - grant<=0, rr_ptr<=(g+1) mod NUM_REQ, byte_cnt<=0, last_f<=0, state=IDLE.
  - Arbitration resumes on the following cycle.
- Minimum spacing between tx_start pulses is 3 cycles: SEND, WAIT_BUSY, WAIT_DONE.
- Fairness: a requester re-requesting right after release gets lowest priority for that arbitration.
- req_valid of non-owners is ignored while granted.
- Simultaneous requests in IDLE: the lowest index at or above rr_ptr (with wrap) wins.
- req_valid[g] dropping in WAIT_BUSY or WAIT_DONE has no effect; it is checked only in SEND.
- Reset mid-transmit: all state clears immediately. A transmitter already shifting completes on its own. The arbiter waits in IDLE and waits for uart_ready=1 in SEND before any new tx_start.
- byte_cnt is 8 bits and never wraps: the forced release at MAX_BYTES bounds it.

Test Plan:
- Single requester: req_valid=4'b0001, bytes 8'h41,8'h42,8'h43 with last on 8'h43, uart_ready modelled 10 cycles busy -> three tx_start pulses with tx_data 41,42,43; req_ack[0] three times; grant returns to 0; rr_ptr=1.
- Round robin: all four requesters valid, single-byte packets -> grant order 0,1,2,3,0; active_id follows 0,1,2,3,0.
- Byte cap: MAX_BYTES=4, requester 2 streams 6 bytes with no last and requesters 0 and 2 both valid -> 4 bytes from 2, release; requester 0 served next; requester 2 resumes afterwards.
- Withdrawal: requester 1 granted, req_valid[1] drops before its first byte -> no tx_start; grant=0 the next cycle; rr_ptr=2.
- Timeout: uart_ready held 1 after tx_start -> tx_timeout pulses exactly BUSY_TO=8 cycles after tx_start; the sequence continues.
- Async reset: assert rst in WAIT_DONE mid-packet -> all outputs zero within the same cycle; after deassertion with uart_ready low, no tx_start until uart_ready=1.
